// File: rtl/seg7_disp_ctrl_if.sv
// Requester-side handshake bundle for seg7_disp_ctrl: two update ports plus their ack pulses.
interface seg7_disp_ctrl_if;
  logic        req0;
  logic [31:0] data0;
  logic [7:0]  point0;
  logic [7:0]  les0;
  logic        mode0;
  logic        req1;
  logic [31:0] data1;
  logic [7:0]  point1;
  logic [7:0]  les1;
  logic        mode1;
  logic        ack0;
  logic        ack1;

  modport master (
    output req0, data0, point0, les0, mode0,
    output req1, data1, point1, les1, mode1,
    input  ack0, ack1
  );

  modport slave (
    input  req0, data0, point0, les0, mode0,
    input  req1, data1, point1, les1, mode1,
    output ack0, ack1
  );
endinterface

// File: rtl/seg7_disp_ctrl.sv
// Scan/flash sequencer and round-robin arbiter for the 8-digit seven-segment driver;
// new content is committed only on the frame boundary where Scan wraps 7->0.
module seg7_disp_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned FLASH_DIV = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_disp_ctrl_if.slave   bus,
  output logic [2:0]        Scan,
  output logic              flash,
  output logic [31:0]       Hexs,
  output logic [7:0]        point,
  output logic [7:0]        LES,
  output logic              SW0,
  output logic              frame_tick
);

  localparam int unsigned DW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FL_MAX  = FW'(FLASH_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic [FW-1:0] fcnt;
  logic          scan_end, frame_end;
  logic          cap_en, commit, grant, last_grant;
  logic          p_gid, p_mode;
  logic [31:0]   p_data;
  logic [7:0]    p_point, p_les;

  assign scan_end  = (div == DIV_MAX);
  assign frame_end = scan_end && (Scan == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      Scan       <= '0;
      fcnt       <= '0;
      flash      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (scan_end) begin
        div  <= '0;
        Scan <= Scan + 3'd1;
      end else begin
        div  <= div + DW'(1);
      end
      if (frame_end) begin
        if (fcnt == FL_MAX) begin
          fcnt  <= '0;
          flash <= ~flash;
        end else begin
          fcnt  <= fcnt + FW'(1);
        end
      end
    end
  end

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    grant = bus.req1;
    if (bus.req0 && bus.req1) grant = ~last_grant;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    commit    = 1'b0;
    bus.ack0  = 1'b0;
    bus.ack1  = 1'b0;
    unique case (state)
      IDLE: if (bus.req0 || bus.req1) begin
        cap_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (frame_end) begin
        commit    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.ack0  = ~p_gid;
        bus.ack1  = p_gid;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      p_gid      <= 1'b0;
      p_data     <= '0;
      p_point    <= '0;
      p_les      <= '0;
      p_mode     <= 1'b1;
      Hexs       <= '0;
      point      <= '0;
      LES        <= '0;
      SW0        <= 1'b1;
    end else begin
      state <= state_nxt;
      if (cap_en) begin
        p_gid      <= grant;
        last_grant <= grant;
        p_data     <= grant ? bus.data1  : bus.data0;
        p_point    <= grant ? bus.point1 : bus.point0;
        p_les      <= grant ? bus.les1   : bus.les0;
        p_mode     <= grant ? bus.mode1  : bus.mode0;
      end
      if (commit) begin
        Hexs  <= p_data;
        point <= p_point;
        LES   <= p_les;
        SW0   <= p_mode;
      end
    end
  end

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Randomized self-checking bench for seg7_disp_ctrl against an edge-count reference model.
module tb_seg7_disp_ctrl;
  localparam int SD    = 4;
  localparam int FD    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  Scan;
  logic        flash, SW0, frame_tick;
  logic [31:0] Hexs;
  logic [7:0]  point, LES;

  seg7_disp_ctrl_if bus ();

  seg7_disp_ctrl #(.SCAN_DIV(SD), .FLASH_DIV(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .Scan       (Scan),
    .flash      (flash),
    .Hexs       (Hexs),
    .point      (point),
    .LES        (LES),
    .SW0        (SW0),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: n = active edges since reset release; one outstanding transaction.
  int          n;
  int          cn;
  bit          busy, lastg, c_gid;
  logic [31:0] c_data, m_hex;
  logic [7:0]  c_pt, c_les, m_pt, m_les;
  logic        c_mode, m_sw;

  int          keep0, keep1;
  bit          rand_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; busy = 0; lastg = 1'b1; cn = 0;
    m_hex = '0; m_pt = '0; m_les = '0; m_sw = 1'b1;
  endtask

  task automatic model_step();
    n++;
    if (busy && n == cn) begin
      m_hex = c_data; m_pt = c_pt; m_les = c_les; m_sw = c_mode;
    end else if (busy && n == cn + 1) begin
      busy = 0;
    end else if (!busy && (bus.req0 || bus.req1)) begin
      c_gid  = (bus.req0 && bus.req1) ? !lastg : bus.req1;
      c_data = c_gid ? bus.data1  : bus.data0;
      c_pt   = c_gid ? bus.point1 : bus.point0;
      c_les  = c_gid ? bus.les1   : bus.les0;
      c_mode = c_gid ? bus.mode1  : bus.mode0;
      lastg  = c_gid;
      cn     = (n / FRAME + 1) * FRAME;
      busy   = 1;
    end
  endtask

  task automatic check_all();
    bit ackc;
    ackc = busy && (n == cn);
    check("scan",  32'(Scan),       32'((n / SD) % 8));
    check("flash", 32'(flash),      32'((n / (FRAME * FD)) % 2));
    check("ftick", 32'(frame_tick), 32'((n > 0) && (n % FRAME == 0)));
    check("ack0",  32'(bus.ack0),   32'(ackc && !c_gid));
    check("ack1",  32'(bus.ack1),   32'(ackc && c_gid));
    check("hexs",  Hexs,            m_hex);
    check("point", 32'(point),      32'(m_pt));
    check("les",   32'(LES),        32'(m_les));
    check("sw0",   32'(SW0),        32'(m_sw));
  endtask

  task automatic new_req(input int p);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.data0 = $urandom; bus.point0 = 8'($urandom);
      bus.les0 = 8'($urandom); bus.mode0 = 1'($urandom);
    end else begin
      bus.req1 = 1'b1; bus.data1 = $urandom; bus.point1 = 8'($urandom);
      bus.les1 = 8'($urandom); bus.mode1 = 1'($urandom);
    end
  endtask

  task automatic drive();
    if (bus.ack0) begin
      if (int'($urandom_range(99)) < keep0) new_req(0); else bus.req0 = 1'b0;
    end else if (rand_en) begin
      if (!bus.req0 && $urandom_range(15) == 0) new_req(0);
      else if (bus.req0 && $urandom_range(7) == 0) bus.data0 = $urandom;
    end
    if (bus.ack1) begin
      if (int'($urandom_range(99)) < keep1) new_req(1); else bus.req1 = 1'b0;
    end else if (rand_en) begin
      if (!bus.req1 && $urandom_range(15) == 0) new_req(1);
      else if (bus.req1 && $urandom_range(7) == 0) bus.data1 = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check_all();
    drive();
  endtask

  // Asynchronous reset mid-cycle, held for one clock edge.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_scan", 32'(Scan), 32'd0);
    check("rst_flash", 32'(flash), 32'd0);
    check("rst_hexs", Hexs, 32'd0);
    check("rst_point", 32'(point), 32'd0);
    check("rst_les", 32'(LES), 32'd0);
    check("rst_sw0", 32'(SW0), 32'd1);
    check("rst_acks", 32'({bus.ack1, bus.ack0}), 32'd0);
    check("rst_ftick", 32'(frame_tick), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.req0 = 1'b0; bus.data0 = '0; bus.point0 = '0; bus.les0 = '0; bus.mode0 = 1'b0;
    bus.req1 = 1'b0; bus.data1 = '0; bus.point1 = '0; bus.les1 = '0; bus.mode1 = 1'b0;
    keep0 = 0; keep1 = 0; rand_en = 0;
    model_reset();
    @(posedge clk);
    do_reset();

    repeat (70) cycle();

    bus.data0 = 32'h12345678; bus.point0 = 8'h00; bus.les0 = 8'hFF; bus.mode0 = 1'b1;
    bus.req0 = 1'b1;
    repeat (3) cycle();
    bus.data0 = 32'hDEADBEEF;
    repeat (40) cycle();

    do_reset();
    bus.data0 = 32'h12345678; bus.point0 = 8'h00; bus.les0 = 8'hFF; bus.mode0 = 1'b1;
    bus.data1 = 32'h557EF7E0; bus.point1 = 8'h0F; bus.les1 = 8'h00; bus.mode1 = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (80) cycle();

    do_reset();
    new_req(0);
    repeat (6) cycle();
    do_reset();
    repeat (40) cycle();

    keep1 = 100;
    new_req(1);
    repeat (70) cycle();
    keep1 = 0;
    repeat (40) cycle();

    rand_en = 1; keep0 = 30; keep1 = 30;
    for (int s = 0; s < 4; s++) begin
      repeat ($urandom_range(300, 900)) cycle();
      do_reset();
    end
    repeat (200) cycle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
